decoder_scan_ctrl: RTL
======================

DECODER_SCAN_CTRL -- requirements
Module: decoder_scan_ctrl

Interface
REQ-001 Parameter: DWELL_W, 8, width of dwell count input.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: start  input  1  request to begin scanning; sampled each rising edge.
REQ-005 Port: stop  input  1  request to abort scanning; sampled each rising edge.
REQ-006 Port: dwell  input  DWELL_W  cycles each channel stays enabled; latched at accepted start.
REQ-007 Port: mask  input  8  channel enables (bit i = channel i); latched at accepted start.
REQ-008 Port: d  output  3  registered channel select driven to the downstream 3:8 decoder.
REQ-009 Port: E  output  1  registered decoder enable.
REQ-010 Port: busy  output  1  high while not in IDLE.
REQ-011 Port: wrap  output  1  one-cycle pulse marking start of a new scan pass.

Function
REQ-012 States: IDLE, SCAN, BLANK (BLANK exists only per REQ-030); all outputs registered.
REQ-013 IDLE: E=0, busy=0, wrap=0; d holds its last value.
REQ-014 Start accepted only when state=IDLE, start=1, stop=0, mask!=8'h00; otherwise ignored.
REQ-015 On accepted start: latch mask; latch dwell, with dwell=0 treated as 1 (dwell_eff).
REQ-016 Cycle after accepted start: state=SCAN, d=lowest set bit of latched mask, E=1, busy=1, wrap=0.
REQ-017 SCAN: E=1 for exactly dwell_eff consecutive cycles per channel, tracked by an internal down-counter.
REQ-018 Next channel = next set bit of latched mask above current index, wrapping modulo 8 to the lowest set bit.
REQ-019 Without BLANK: the cycle after the last dwell cycle shows d=next channel, E=1 (no gap).
REQ-020 wrap=1 for exactly one cycle: the first cycle d shows a channel whose index is <= the previous channel's (includes single-channel mask); never on the first channel after start.
REQ-021 stop=1 in any non-IDLE state: next cycle state=IDLE, E=0, busy=0, wrap=0; current dwell truncated.
REQ-022 start and stop both 1 in IDLE: stop wins; remain IDLE.
REQ-023 start while busy: ignored; dwell and mask inputs changing while busy: ignored.
REQ-024 d is never X after reset; E=1 only with d pointing at a channel set in the latched mask.
REQ-025 Full-width dwell (2^DWELL_W - 1) supported without counter overflow.

Reset
REQ-026 rst=1 at a rising edge: state=IDLE, d=3'b000, E=0, busy=0, wrap=0, counter=0, latched mask=0.
REQ-027 rst dominates start and stop in the same cycle.
REQ-028 rst mid-scan: outputs reach reset values the cycle after the sampling edge; no partial dwell resumes.
REQ-029 After rst deasserts, first start accepted on the first rising edge with rst=0.

Configuration
REQ-030 Macro SCAN_BLANK_EN defined: one BLANK cycle between channels; in BLANK, d=next channel, E=0, busy=1; wrap pulses in the BLANK cycle when REQ-020 applies; next cycle returns to SCAN with E=1.
REQ-031 SCAN_BLANK_EN undefined: BLANK state absent; channel transitions per REQ-019.
REQ-032 stop and rst in BLANK behave exactly as in SCAN.

Verification
REQ-033 mask=8'hFF, dwell=2, no macro: d steps 0,0,1,1,...,7,7,0; E continuously 1; wrap high on the cycle d returns to 0.
REQ-034 mask=8'b1010_0100, dwell=3: d sequence 2,5,7,2 with 3 cycles each; wrap only on return to 2.
REQ-035 mask=8'h10, dwell=0: d=4, E=1 held; wrap pulses every cycle after the first.
REQ-036 start=stop=1 in IDLE, then start with mask=0: both ignored; busy stays 0.
REQ-037 Scan mid-dwell, assert stop one cycle: next cycle E=0, busy=0; rst mid-scan: d=0, E=0 next cycle.
REQ-038 SCAN_BLANK_EN, mask=8'h03, dwell=1: E pattern 1,0,1,0; d 0,1,1,0,0; wrap in the BLANK cycle with d=0.

Source files
------------

// File: rtl/decoder_scan_ctrl.sv
// decoder_scan_ctrl: scans enabled channels of a 3:8 decoder, dwelling per channel; define SCAN_BLANK_EN for a blank cycle between channels
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         mask,
  output logic [2:0]         d,
  output logic               E,
  output logic               busy,
  output logic               wrap
);
  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
  state_t state;
  logic [DWELL_W-1:0] cnt, ldwell;
  logic [7:0] lmask;
  logic [2:0] nxt, low;
  // next enabled channel above d (modulo 8), and lowest enabled channel of the start mask
  always_comb begin
    nxt = d;
    low = 3'd0;
    for (int k = 7; k >= 1; k--) nxt = lmask[3'(d + 3'(k))] ? 3'(d + 3'(k)) : nxt;
    for (int k = 7; k >= 0; k--) low = mask[k] ? 3'(k) : low;
  end
  // scan state machine with registered outputs; cnt holds remaining dwell cycles after the current one
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      d      <= 3'd0;
      E      <= 1'b0;
      busy   <= 1'b0;
      wrap   <= 1'b0;
      cnt    <= '0;
      ldwell <= '0;
      lmask  <= '0;
    end else if (state == IDLE) begin
      wrap <= 1'b0;
      if (start && !stop && |mask) begin
        state  <= SCAN;
        lmask  <= mask;
        ldwell <= (dwell == '0) ? DWELL_W'(1) : dwell;
        cnt    <= (dwell == '0) ? '0 : dwell - 1'b1;
        d      <= low;
        E      <= 1'b1;
        busy   <= 1'b1;
      end
    end else if (stop) begin
      state <= IDLE;
      E     <= 1'b0;
      busy  <= 1'b0;
      wrap  <= 1'b0;
      cnt   <= '0;
    end else if (state == BLANK) begin
      state <= SCAN;
      E     <= 1'b1;
      wrap  <= 1'b0;
      cnt   <= ldwell - 1'b1;
    end else if (cnt != '0) begin
      cnt  <= cnt - 1'b1;
      wrap <= 1'b0;
    end else begin
      d    <= nxt;
      wrap <= nxt <= d;
`ifdef SCAN_BLANK_EN
      state <= BLANK;
      E     <= 1'b0;
`else
      cnt   <= ldwell - 1'b1;
`endif
    end
  end
endmodule
